ft_out_mux: RTL and testbench

//  Output stage toward the FT2232 in asynchronous FIFO (FT245-style) write mode.
//  - Arbitrates round-robin among N byte-stream requesters (register manager reply, timetag stream, ...).
//  - Serialises the granted stream onto the FT2232 write pins with WR# timing.
//  - Pulses the per-port omux_sel once per byte accepted.
//  - Grant is locked while the granted req stays high, so multi-byte replies are never interleaved.

---
 rtl/ft_out_mux_pkg.sv | 33 +++
 rtl/ft_out_mux_rr_arbiter.sv | 33 +++
 rtl/ft_out_mux.sv | 154 +++++++++++++++
 tb/tb_ft_out_mux.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_out_mux_pkg.sv
// Shared definitions for the FT2232 async-FIFO interface blocks:
// FSM state encoding, default bus timing and counter sizing helpers.
package ft_out_mux_pkg;

  localparam int unsigned FT_DATA_W          = 8;
  localparam int unsigned FT_SETUP_CYCLES    = 1;
  localparam int unsigned FT_WR_CYCLES       = 2;
  localparam int unsigned FT_RECOVER_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_WAIT_TXE = 3'd4
  } omux_state_e;

  // Width of a cycle counter able to hold the largest phase length.
  function automatic int unsigned cycle_cnt_w(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ft_out_mux_rr_arbiter.sv
// Round-robin priority select: first requester at or after the pointer,
// wrapping modulo N_PORTS. Purely combinational.
module ft_out_mux_rr_arbiter
  import ft_out_mux_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned IDX_W   = port_idx_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_PORTS);
      if (!found && req[cand]) begin
        found         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = cand;
      end
    end
  end

endmodule

// File: rtl/ft_out_mux.sv
// FT2232 async-FIFO write-side output stage: round-robin arbitration among
// byte-stream requesters and WR# strobe generation with setup/recover timing.
module ft_out_mux
  import ft_out_mux_pkg::*;
#(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned SETUP_CYCLES   = FT_SETUP_CYCLES,
  parameter int unsigned WR_CYCLES      = FT_WR_CYCLES,
  parameter int unsigned RECOVER_CYCLES = FT_RECOVER_CYCLES
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [N_PORTS-1:0]             req_i,
  input  logic [FT_DATA_W*N_PORTS-1:0]   data_i,
  output logic [N_PORTS-1:0]             sel_o,
  input  logic                           ft_txe_n_i,
  output logic                           ft_wr_o,
  output logic [FT_DATA_W-1:0]           ft_data_o,
  output logic                           ft_data_oe_o,
  output logic                           busy_o
);

  localparam int unsigned IDX_W = port_idx_w(N_PORTS);
  localparam int unsigned CNT_W = cycle_cnt_w(SETUP_CYCLES, WR_CYCLES, RECOVER_CYCLES);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_PRE     = CNT_W'(WR_CYCLES - 2);
  localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_PORT  = IDX_W'(N_PORTS - 1);

  logic [1:0]           txe_sync;
  logic                 txe_s;
  omux_state_e          state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     grant_idx;
  logic [N_PORTS-1:0]   grant_oh;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_next;
  logic                 grant_req;
  logic [N_PORTS-1:0]   arb_grant_c;
  logic [IDX_W-1:0]     arb_idx_c;
  logic [FT_DATA_W-1:0] port_byte [N_PORTS];

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port_byte
    assign port_byte[k] = data_i[FT_DATA_W*k +: FT_DATA_W];
  end

  assign txe_s     = txe_sync[1];
  assign grant_req = req_i[grant_idx];
  assign rr_next   = (grant_idx == LAST_PORT) ? '0 : grant_idx + IDX_W'(1);

  // TXE# is driven by the FT2232 clock domain; resynchronise before use.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) txe_sync <= 2'b11;
    else         txe_sync <= {txe_sync[0], ft_txe_n_i};
  end

  ft_out_mux_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req_i),
    .ptr     (rr_ptr),
    .grant_c (arb_grant_c),
    .idx_c   (arb_idx_c)
  );

  // Byte sequencer; grant stays locked until the owner drops its request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      grant_idx    <= '0;
      grant_oh     <= '0;
      rr_ptr       <= '0;
      sel_o        <= '0;
      ft_wr_o      <= 1'b0;
      ft_data_o    <= '0;
      ft_data_oe_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      sel_o <= '0;
      case (state)
        ST_IDLE: begin
          if ((|req_i) && !txe_s) begin
            grant_idx    <= arb_idx_c;
            grant_oh     <= arb_grant_c;
            ft_data_o    <= port_byte[arb_idx_c];
            ft_data_oe_o <= 1'b1;
            busy_o       <= 1'b1;
            cnt          <= '0;
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt     <= '0;
            ft_wr_o <= 1'b1;
            state   <= ST_STROBE;
            if (WR_CYCLES == 1) sel_o <= grant_oh;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (cnt == WR_LAST) begin
            cnt     <= '0;
            ft_wr_o <= 1'b0;
            state   <= ST_RECOVER;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // sel lands on the final strobe cycle
            if (WR_CYCLES > 1 && cnt == WR_PRE) sel_o <= grant_oh;
          end
        end
        ST_RECOVER: begin
          if (cnt == REC_LAST) begin
            cnt <= '0;
            if (!grant_req) begin
              grant_oh     <= '0;
              ft_data_oe_o <= 1'b0;
              busy_o       <= 1'b0;
              rr_ptr       <= rr_next;
              state        <= ST_IDLE;
            end else if (!txe_s) begin
              ft_data_o <= port_byte[grant_idx];
              state     <= ST_SETUP;
            end else begin
              state <= ST_WAIT_TXE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_TXE: begin
          if (!grant_req) begin
            grant_oh     <= '0;
            ft_data_oe_o <= 1'b0;
            busy_o       <= 1'b0;
            rr_ptr       <= rr_next;
            state        <= ST_IDLE;
          end else if (!txe_s) begin
            ft_data_o <= port_byte[grant_idx];
            cnt       <= '0;
            state     <= ST_SETUP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_out_mux.sv
// Directed bench for ft_out_mux: requester models driven from byte queues,
// bus capture on WR rising edge, immediate-assertion checks.
module tb_ft_out_mux;

  logic        clk_i;
  logic        reset_i;
  logic [1:0]  req_i;
  logic [15:0] data_i;
  logic [1:0]  sel_o;
  logic        ft_txe_n_i;
  logic        ft_wr_o;
  logic [7:0]  ft_data_o;
  logic        ft_data_oe_o;
  logic        busy_o;

  ft_out_mux #(
    .N_PORTS        (2),
    .SETUP_CYCLES   (1),
    .WR_CYCLES      (2),
    .RECOVER_CYCLES (2)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .data_i       (data_i),
    .sel_o        (sel_o),
    .ft_txe_n_i   (ft_txe_n_i),
    .ft_wr_o      (ft_wr_o),
    .ft_data_o    (ft_data_o),
    .ft_data_oe_o (ft_data_oe_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int         total;
  int         bad;
  int         cyc;
  logic [7:0] src0[$];
  logic [7:0] src1[$];
  int         pos0;
  int         pos1;
  logic       hold0;
  logic       hold1;
  logic [7:0] cap[$];
  logic [7:0] expq[$];
  int         rise_cyc[$];
  int         fall_cyc[$];
  int         sel_cnt0;
  int         sel_cnt1;
  logic       prev_wr;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    req_i[0]    = hold0 && (pos0 < src0.size());
    req_i[1]    = hold1 && (pos1 < src1.size());
    data_i[7:0]  = (pos0 < src0.size()) ? src0[pos0] : 8'h00;
    data_i[15:8] = (pos1 < src1.size()) ? src1[pos1] : 8'h00;
  endtask

  task automatic new_test();
    src0.delete();
    src1.delete();
    pos0 = 0;
    pos1 = 0;
    hold0 = 1'b1;
    hold1 = 1'b1;
    cap.delete();
    expq.delete();
    rise_cyc.delete();
    fall_cyc.delete();
    sel_cnt0 = 0;
    sel_cnt1 = 0;
  endtask

  // One clock; observe #1 after the edge, then let the requesters react.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (ft_wr_o && !prev_wr) begin
      cap.push_back(ft_data_o);
      rise_cyc.push_back(cyc);
    end
    if (!ft_wr_o && prev_wr) fall_cyc.push_back(cyc);
    if (ft_wr_o && prev_wr) chk("data_stable_under_wr", 32'(ft_data_o), 32'(prev_data));
    chk("sel_onehot0", 32'($onehot0(sel_o)), 32'd1);
    if (ft_wr_o) chk("wr_implies_oe_busy", 32'({ft_data_oe_o, busy_o}), 32'd3);
    prev_wr   = ft_wr_o;
    prev_data = ft_data_o;
    if (sel_o[0]) begin
      sel_cnt0++;
      if (pos0 < src0.size()) pos0++;
    end
    if (sel_o[1]) begin
      sel_cnt1++;
      if (pos1 < src1.size()) pos1++;
    end
    drive_reqs();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy_o || (|req_i)) && n < budget);
    chk({tag, "_idle"}, 32'(!busy_o && !(|req_i)), 32'd1);
  endtask

  task automatic chk_cap(input string tag);
    chk({tag, "_count"}, 32'(cap.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < cap.size()) chk(tag, 32'(cap[i]), 32'(expq[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int ncap;
    int n;
    total = 0;
    bad = 0;
    cyc = 0;
    prev_wr = 1'b0;
    prev_data = 8'h00;
    reset_i = 1'b1;
    ft_txe_n_i = 1'b0;
    req_i = '0;
    data_i = '0;
    new_test();
    drive_reqs();
    #1;
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_wr", 32'(ft_wr_o), 32'd0);
    chk("rst_data", 32'(ft_data_o), 32'd0);
    chk("rst_oe", 32'(ft_data_oe_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    repeat (3) tick();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Single multi-byte reply on port 0
    new_test();
    src0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_reqs();
    run_until_idle("t1", 200);
    expq = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk_cap("t1_order");
    chk("t1_sel0", 32'(sel_cnt0), 32'd4);
    chk("t1_sel1", 32'(sel_cnt1), 32'd0);
    chk("t1_falls", 32'(fall_cyc.size()), 32'd4);
    for (int i = 1; i < rise_cyc.size(); i++)
      chk("t1_spacing", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd5);
    for (int i = 0; i < rise_cyc.size() && i < fall_cyc.size(); i++)
      chk("t1_width", 32'(fall_cyc[i] - rise_cyc[i]), 32'd2);

    // Contention with pointer at port 1 (port 0 was served last)
    new_test();
    src0 = '{8'hA0, 8'hA1};
    src1 = '{8'hB0, 8'hB1};
    drive_reqs();
    run_until_idle("t2a", 200);
    expq = '{8'hB0, 8'hB1, 8'hA0, 8'hA1};
    chk_cap("t2a_order");

    // Port 1 alone moves the pointer back to port 0
    new_test();
    src1 = '{8'h5A};
    drive_reqs();
    run_until_idle("t2p", 100);
    expq = '{8'h5A};
    chk_cap("t2p_order");

    new_test();
    src0 = '{8'hA0, 8'hA1};
    src1 = '{8'hB0, 8'hB1};
    drive_reqs();
    run_until_idle("t2b", 200);
    expq = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
    chk_cap("t2b_order");
    chk("t2b_sel0", 32'(sel_cnt0), 32'd2);
    chk("t2b_sel1", 32'(sel_cnt1), 32'd2);

    // Backpressure: TXE# high after byte 2
    new_test();
    src0 = '{8'h31, 8'h32, 8'h33, 8'h34};
    drive_reqs();
    n = 0;
    while (sel_cnt0 < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_reach_byte2", 32'(sel_cnt0), 32'd2);
    ft_txe_n_i = 1'b1;
    ncap = cap.size();
    repeat (20) tick();
    chk("t3_no_wr", 32'(cap.size()), 32'(ncap));
    chk("t3_busy_held", 32'(busy_o), 32'd1);
    chk("t3_oe_held", 32'(ft_data_oe_o), 32'd1);
    chk("t3_wr_low", 32'(ft_wr_o), 32'd0);
    c0 = cyc;
    ft_txe_n_i = 1'b0;
    run_until_idle("t3", 200);
    expq = '{8'h31, 8'h32, 8'h33, 8'h34};
    chk_cap("t3_order");
    if (rise_cyc.size() > 2) chk("t3_resume_cycle", 32'(rise_cyc[2] - c0), 32'd4);

    // Request dropped during SETUP of the first byte
    new_test();
    src0 = '{8'h77, 8'h78};
    drive_reqs();
    c0 = cyc;
    tick();
    chk("t4_granted", 32'(busy_o), 32'd1);
    hold0 = 1'b0;
    drive_reqs();
    repeat (4) tick();
    chk("t4_busy_in_recover", 32'(busy_o), 32'd1);
    tick();
    chk("t4_busy_released", 32'(busy_o), 32'd0);
    chk("t4_oe_released", 32'(ft_data_oe_o), 32'd0);
    expq = '{8'h77};
    chk_cap("t4_order");
    chk("t4_sel0", 32'(sel_cnt0), 32'd1);
    if (rise_cyc.size() > 0) chk("t4_latency", 32'(rise_cyc[0] - c0), 32'd2);

    // Reset asserted while WR is high
    new_test();
    src0 = '{8'hC1, 8'hC2};
    drive_reqs();
    n = 0;
    while (!ft_wr_o && n < 50) begin
      tick();
      n++;
    end
    chk("t5_wr_seen", 32'(ft_wr_o), 32'd1);
    reset_i = 1'b1;
    #1;
    chk("t5_wr_async", 32'(ft_wr_o), 32'd0);
    chk("t5_sel_async", 32'(sel_o), 32'd0);
    chk("t5_oe_async", 32'(ft_data_oe_o), 32'd0);
    chk("t5_busy_async", 32'(busy_o), 32'd0);
    new_test();
    drive_reqs();
    tick();
    reset_i = 1'b0;
    tick();
    new_test();
    src0 = '{8'hD5};
    drive_reqs();
    run_until_idle("t5", 100);
    expq = '{8'hD5};
    chk_cap("t5_order");
    chk("t5_sel0", 32'(sel_cnt0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
